sw_target_feeder: RTL and testbench
===================================

Name: sw_target_feeder

Overview:
Upstream feeder for the Smith-Waterman scoring array. It buffers two independent target-sequence streams (channel 0 and channel 1) in per-channel FIFOs. It interleaves them onto the array's single 2-bit target-base input, following the array's toggle flag, and generates the per-channel enables that frame each sequence.

Parameters:
DEPTH, 256, bases per channel FIFO; must be at least the longest target sequence.
ADDR_WIDTH, log2b(DEPTH), FIFO pointer width.
GAP_SLOTS, 2, own-channel slots with enable low inserted after each sequence (minimum 1).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active low
wr0_en  in  1  push a base into channel 0 FIFO
wr0_base  in  2  target base for channel 0
wr0_last  in  1  pushed base is the final base of its sequence
wr1_en  in  1  push for channel 1
wr1_base  in  2  target base for channel 1
wr1_last  in  1  last flag for channel 1
toggle_in  in  1  array toggle flag; 0 = channel 0 slot, 1 = channel 1 slot
full0  out  1  channel 0 FIFO full
full1  out  1  channel 1 FIFO full
ovf0  out  1  sticky: channel 0 push dropped
ovf1  out  1  sticky: channel 1 push dropped
data_out  out  2  target base to the array
en0  out  1  channel 0 sequence enable (level)
en1  out  1  channel 1 sequence enable (level)
busy0  out  1  channel 0 not IDLE
busy1  out  1  channel 1 not IDLE

Behaviour:
- Reset: all outputs are registered. On rst low at a clock edge:
  - data_out, en0, en1, full*, ovf*, busy* = 0.
  - FIFOs are emptied and sequence counters cleared.
  - Both FSMs go to IDLE.
  - Reset mid-sequence discards all buffered and in-flight data.
- FIFO storage: each FIFO entry holds {last, base[1:0]}, giving a 3-bit word.
- Push rules:
  - A push with full=1 is dropped and sets ovf until reset.
  - The push is dropped even if a pop occurs the same cycle.
  - Pointers wrap modulo DEPTH.
  - full is asserted when the count equals DEPTH.
- Sequence counter seq_cnt (per channel, ADDR_WIDTH+1 bits):
  - Increments on an accepted push with last=1.
  - Decrements on a pop of an entry with last=1.
  - Simultaneous increment and decrement leaves it unchanged.
  - A channel starts a sequence only when seq_cnt > 0, i.e. the complete sequence is buffered. Mid-sequence underflow is therefore impossible.
- Slot rule: at each rising edge, channel c acts only if toggle_in == c. The other channel's en and state hold.
- Per-channel FSM (IDLE, FEED, GAP), evaluated on own slot only:
  - IDLE: en_c = 0. If seq_cnt > 0: pop, data_out <= base, en_c <= 1, busy_c <= 1. Next state is GAP if last, else FEED.
  - FEED: pop, data_out <= base, en_c <= 1. On last go to GAP and load gap_cnt <= GAP_SLOTS-1.
  - GAP: en_c <= 0, data_out <= 0. While gap_cnt != 0, decrement. When gap_cnt == 0, go to IDLE and set busy_c <= 0.
- The first GAP slot has en low. A total of GAP_SLOTS en-low own slots occur before IDLE can restart; the IDLE restart slot then re-asserts en in that same slot.
- data_out is driven only on a slot whose channel is in IDLE-start, FEED, or GAP. An IDLE channel with no work leaves data_out holding its previous value.
- Timing:
  - A single-base sequence produces exactly one own slot with en high.
  - Consecutive bases of one channel appear two cycles apart, provided toggle_in alternates.
  - Latency: a last-push accepted at edge t makes seq_cnt > 0 after t. The first own slot at edge t+1 or later issues the first base, visible after that edge.
- If toggle_in stops alternating, only the selected channel advances; the other simply waits.

Test Plan:
- Reset then idle, toggle alternating -> data_out=0, en0=en1=0, busy*=0, full*=0.
- Push ch0 bases A,G,T,C (last on C) -> en0 high for 4 consecutive toggle_in=0 slots with data_out 10,11,00,01; en0 low for 2 slots; busy0 falls after the second gap slot; en1 stays 0.
- Ch0 sequence T,T (last) and ch1 sequence G (last) pushed together -> data_out alternates 00(ch0),11(ch1),00(ch0); en1 high for one slot only; both FSMs run independently.
- Push 3 bases without last -> en0 stays 0 indefinitely. Push a 4th base with last -> sequence starts at the next toggle_in=0 slot.
- Fill ch1 to DEPTH, then push 1 more -> full1=1, ovf1=1 stays set, FIFO contents unchanged. Reset -> ovf1=0, full1=0.
- Reset asserted while ch0 is in FEED at the 2nd base -> en0=0 next cycle; after release, with no new pushes, en0 stays 0.

Source files
------------

// File: rtl/sw_target_feeder.sv
// Target-base feeder for the Smith-Waterman array: two buffered channels
// interleaved onto one 2-bit bus under the array's toggle flag.
module sw_target_feeder #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int GAP_SLOTS  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr0_en,
    input  logic [1:0] wr0_base,
    input  logic       wr0_last,
    input  logic       wr1_en,
    input  logic [1:0] wr1_base,
    input  logic       wr1_last,
    input  logic       toggle_in,
    output logic       full0,
    output logic       full1,
    output logic       ovf0,
    output logic       ovf1,
    output logic [1:0] data_out,
    output logic       en0,
    output logic       en1,
    output logic       busy0,
    output logic       busy1
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int GAP_W = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [1:0] wr_en_a;
    logic [1:0] wr_last_a;
    logic [1:0] wr_base_a [2];

    logic [1:0] full_r;
    logic [1:0] ovf_r;
    logic [1:0] en_r;
    logic [1:0] busy_r;
    logic [1:0] ch_drive;
    logic [1:0] ch_data [2];

    assign wr_en_a      = {wr1_en, wr0_en};
    assign wr_last_a    = {wr1_last, wr0_last};
    assign wr_base_a[0] = wr0_base;
    assign wr_base_a[1] = wr1_base;

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [2:0]            mem [DEPTH];
        logic [ADDR_WIDTH-1:0] wr_ptr;
        logic [ADDR_WIDTH-1:0] rd_ptr;
        logic [CNT_W-1:0]      count;
        logic [CNT_W-1:0]      count_next;
        logic [CNT_W-1:0]      seq_cnt;
        logic [GAP_W-1:0]      gap_cnt;
        state_t                state;
        logic                  full_q;
        logic                  ovf_q;
        logic                  en_q;
        logic                  busy_q;
        logic                  slot;
        logic                  push;
        logic                  pop;
        logic                  can_start;
        logic                  head_last;
        logic [1:0]            head_base;
        logic                  seq_inc;
        logic                  seq_dec;

        assign slot      = (toggle_in == 1'(c));
        assign {head_last, head_base} = mem[rd_ptr];
        // A sequence may only start once its last base is buffered, so the
        // FEED state can pop blindly without ever seeing an empty FIFO.
        assign can_start = (state == IDLE) && (seq_cnt != '0);
        assign pop       = slot && (can_start || (state == FEED));
        assign push      = wr_en_a[c] && !full_q;
        assign seq_inc   = push && wr_last_a[c];
        assign seq_dec   = pop && head_last;

        assign ch_drive[c] = slot && (can_start || (state == FEED) || (state == GAP));
        assign ch_data[c]  = (state == GAP) ? 2'b00 : head_base;

        assign full_r[c] = full_q;
        assign ovf_r[c]  = ovf_q;
        assign en_r[c]   = en_q;
        assign busy_r[c] = busy_q;

        always_comb begin
            count_next = count;
            case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst && push) begin
                mem[wr_ptr] <= {wr_last_a[c], wr_base_a[c]};
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                seq_cnt <= '0;
                full_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= (wr_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr + ADDR_WIDTH'(1);
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + ADDR_WIDTH'(1);
                end
                if (wr_en_a[c] && full_q) begin
                    ovf_q <= 1'b1;
                end
                count  <= count_next;
                full_q <= (count_next == CNT_W'(DEPTH));
                case ({seq_inc, seq_dec})
                    2'b10:   seq_cnt <= seq_cnt + CNT_W'(1);
                    2'b01:   seq_cnt <= seq_cnt - CNT_W'(1);
                    default: seq_cnt <= seq_cnt;
                endcase
            end
        end

        // The channel FSM only moves on its own slot; on the other
        // channel's slot everything here holds.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state   <= IDLE;
                gap_cnt <= '0;
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else if (slot) begin
                case (state)
                    IDLE: begin
                        if (seq_cnt != '0) begin
                            en_q   <= 1'b1;
                            busy_q <= 1'b1;
                            if (head_last) begin
                                state   <= GAP;
                                gap_cnt <= GAP_W'(GAP_SLOTS - 1);
                            end else begin
                                state <= FEED;
                            end
                        end else begin
                            en_q <= 1'b0;
                        end
                    end
                    FEED: begin
                        en_q <= 1'b1;
                        if (head_last) begin
                            state   <= GAP;
                            gap_cnt <= GAP_W'(GAP_SLOTS - 1);
                        end
                    end
                    GAP: begin
                        en_q <= 1'b0;
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // An idle channel with nothing to send leaves the bus value untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out <= 2'b00;
        end else if (ch_drive[toggle_in]) begin
            data_out <= ch_data[toggle_in];
        end
    end

    assign full0 = full_r[0];
    assign full1 = full_r[1];
    assign ovf0  = ovf_r[0];
    assign ovf1  = ovf_r[1];
    assign en0   = en_r[0];
    assign en1   = en_r[1];
    assign busy0 = busy_r[0];
    assign busy1 = busy_r[1];

endmodule

// File: tb/tb_sw_target_feeder.sv
// Scoreboard bench for sw_target_feeder: a slot-level model predicts every
// cycle's outputs, a monitor compares them after each rising edge.
module tb_sw_target_feeder;

    localparam int DEPTH     = 256;
    localparam int GAP_SLOTS = 2;

    localparam logic [1:0] BA = 2'b10;
    localparam logic [1:0] BG = 2'b11;
    localparam logic [1:0] BT = 2'b00;
    localparam logic [1:0] BC = 2'b01;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr0_en, wr0_last, wr1_en, wr1_last, toggle_in;
    logic [1:0] wr0_base, wr1_base;
    logic       full0, full1, ovf0, ovf1, en0, en1, busy0, busy1;
    logic [1:0] data_out;

    always #5 clk = ~clk;

    sw_target_feeder #(.DEPTH(DEPTH), .GAP_SLOTS(GAP_SLOTS)) dut (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_base(wr0_base), .wr0_last(wr0_last),
        .wr1_en(wr1_en), .wr1_base(wr1_base), .wr1_last(wr1_last),
        .toggle_in(toggle_in),
        .full0(full0), .full1(full1), .ovf0(ovf0), .ovf1(ovf1),
        .data_out(data_out), .en0(en0), .en1(en1),
        .busy0(busy0), .busy1(busy1)
    );

    // {data_out, en0, en1, busy0, busy1, full0, full1, ovf0, ovf1}
    typedef logic [9:0] obs_t;
    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    bit   tog_state = 1'b1;

    // Reference model: buffered entries per channel plus slot bookkeeping.
    logic [2:0] mq0[$];
    logic [2:0] mq1[$];
    int         complete [2];
    bit         in_seq   [2];
    int         gap_left [2];
    bit         ovf_m    [2];
    bit         en_m     [2];
    logic [1:0] data_m;

    function automatic int qsize(input int ch);
        return (ch == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [2:0] qpop(input int ch);
        if (ch == 0) return mq0.pop_front();
        return mq1.pop_front();
    endfunction

    function automatic void qpush(input int ch, input logic [2:0] v);
        if (ch == 0) mq0.push_back(v);
        else         mq1.push_back(v);
    endfunction

    task automatic modelStep();
        int         pre [2];
        bit         we  [2];
        logic [2:0] wv  [2];
        int         c;
        logic [2:0] e;
        obs_t       o;
        if (!rst) begin
            mq0.delete();
            mq1.delete();
            for (int i = 0; i < 2; i++) begin
                complete[i] = 0; in_seq[i] = 0; gap_left[i] = 0;
                ovf_m[i] = 0; en_m[i] = 0;
            end
            data_m = 2'b00;
        end else begin
            pre[0] = qsize(0);  pre[1] = qsize(1);
            we[0]  = wr0_en;    we[1]  = wr1_en;
            wv[0]  = {wr0_last, wr0_base};
            wv[1]  = {wr1_last, wr1_base};
            c = toggle_in ? 1 : 0;
            if (gap_left[c] > 0) begin
                en_m[c] = 0;
                data_m  = 2'b00;
                gap_left[c]--;
            end else if (in_seq[c] || complete[c] > 0) begin
                e = qpop(c);
                en_m[c]   = 1;
                data_m    = e[1:0];
                in_seq[c] = !e[2];
                if (e[2]) begin
                    complete[c]--;
                    gap_left[c] = GAP_SLOTS;
                end
            end else begin
                en_m[c] = 0;
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (we[ch]) begin
                    if (pre[ch] == DEPTH) ovf_m[ch] = 1;
                    else begin
                        qpush(ch, wv[ch]);
                        if (wv[ch][2]) complete[ch]++;
                    end
                end
            end
        end
        o = {data_m, en_m[0], en_m[1],
             (in_seq[0] || gap_left[0] > 0), (in_seq[1] || gap_left[1] > 0),
             (qsize(0) == DEPTH), (qsize(1) == DEPTH), ovf_m[0], ovf_m[1]};
        exp_q.push_back(o);
    endtask

    task automatic applyStimulus(input bit r,
                                 input bit e0, input logic [1:0] b0, input bit l0,
                                 input bit e1, input logic [1:0] b1, input bit l1,
                                 input bit tog);
        @(negedge clk);
        rst = r;
        wr0_en = e0; wr0_base = b0; wr0_last = l0;
        wr1_en = e1; wr1_base = b1; wr1_last = l1;
        toggle_in = tog;
        modelStep();
    endtask

    function automatic bit nextTog();
        tog_state = ~tog_state;
        return tog_state;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 2'b00, 0, 0, 2'b00, 0, nextTog());
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'b00, 0, 0, 2'b00, 0, nextTog());
    endtask

    task automatic push0(input logic [1:0] b, input bit l);
        applyStimulus(1, 1, b, l, 0, 2'b00, 0, nextTog());
    endtask

    task automatic checkOutput(input obs_t expv);
        obs_t act;
        act = {data_out, en0, en1, busy0, busy1, full0, full1, ovf0, ovf1};
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL outputs cycle %0d: got data=%b en=%b%b busy=%b%b full=%b%b ovf=%b%b expected data=%b en=%b%b busy=%b%b full=%b%b ovf=%b%b",
                     cycle, act[9:8], act[7], act[6], act[5], act[4], act[3], act[2], act[1], act[0],
                     expv[9:8], expv[7], expv[6], expv[5], expv[4], expv[3], expv[2], expv[1], expv[0]);
        end
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        bit r, e0, l0, e1, l1;
        logic [1:0] b0, b1;
        rst = 0; toggle_in = 0;
        wr0_en = 0; wr0_base = 0; wr0_last = 0;
        wr1_en = 0; wr1_base = 0; wr1_last = 0;
        $display("[TB] starting");

        resetCycles(3);
        idle(6);

        push0(BA, 0); push0(BG, 0); push0(BT, 0); push0(BC, 1);
        idle(20);

        applyStimulus(1, 1, BT, 0, 1, BG, 1, nextTog());
        push0(BT, 1);
        idle(20);

        push0(BA, 0); push0(BC, 0); push0(BG, 0);
        idle(12);
        push0(BT, 1);
        idle(20);

        for (int i = 0; i <= DEPTH; i++)
            applyStimulus(1, 0, 2'b00, 0, 1, 2'(i), 0, nextTog());
        applyStimulus(1, 0, 2'b00, 0, 1, BC, 1, nextTog());
        idle(6);
        resetCycles(2);
        idle(6);

        push0(BG, 0); push0(BA, 0); push0(BC, 0); push0(BT, 1);
        idle(4);
        resetCycles(1);
        idle(12);

        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 599) != 0);
            e0 = ($urandom_range(0, 9) < 3);
            e1 = ($urandom_range(0, 9) < 3);
            b0 = 2'($urandom_range(0, 3));
            b1 = 2'($urandom_range(0, 3));
            l0 = ($urandom_range(0, 3) == 0);
            l1 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) < 8) tog_state = ~tog_state;
            applyStimulus(r, e0, b0, l0, e1, b1, l1, tog_state);
        end
        idle(40);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
